// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller slice.
// Holds the controller state encoding, the default vector table layout and
// a helper that sizes the interrupt id field from the number of lines.
package int_pkg;

   // Controller states, kept as plain constants so older code can compare
   // against them directly.
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] TAKE    = 2'd1;
   localparam logic [1:0] SERVICE = 2'd2;

   // Default vector table: vector 0 at 10'h3C0, one vector every 4 words.
   localparam logic [9:0] VEC_BASE_DEFAULT   = 10'h3C0;
   localparam int         VEC_STRIDE_DEFAULT = 4;

   // Width of an id field able to name every request line (at least 1 bit).
   function automatic int irq_id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/int_controller_prio_enc.sv
// Combinational priority encoder for the interrupt controller.
// Ports:
//   req   - request vector, bit 0 is the highest priority
//   valid - high when any request bit is set
//   idx   - index of the lowest set bit (0 when no bit is set)
module prio_enc
   import int_pkg::*;
#(
   parameter int NIRQ = 4
) (
   input  logic [NIRQ-1:0]               req,
   output logic                          valid,
   output logic [irq_id_width(NIRQ)-1:0] idx
);

   localparam int IDW = irq_id_width(NIRQ);

   // Scan from the top down so the lowest set index is written last and wins.
   always_comb begin
      valid = |req;
      idx   = '0;
      for (int i = NIRQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = IDW'(i);
         end
      end
   end

endmodule

// File: rtl/int_controller.sv
// Interrupt controller sequencing the single-cycle CPU datapath.
// Captures rising edges on the request lines into pending bits, picks the
// highest-priority enabled request at an instruction boundary, forces the PC
// to the matching vector while the current PC is pushed and the fetched
// instruction is killed, then stays in service until reti.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   irq                   - request lines, synchronous to clk
//   ien_we / ien_wd       - per-line enable mask write
//   gie_we / gie_wd       - global enable write
//   pend_clr              - software clear of pending bits
//   reti                  - decoded return-from-interrupt
//   int_take              - one-cycle pulse: load vector, push PC
//   kill                  - suppress all writes of the current instruction
//   int_vector            - next-PC value while int_take is high
//   irq_id                - id being taken or in service
//   in_service            - high from int_take through the reti cycle
//   pending               - pending bits, readable by software
module int_controller
   import int_pkg::*;
#(
   parameter int         NIRQ       = 4,
   parameter logic [9:0] VEC_BASE   = VEC_BASE_DEFAULT,
   parameter int         VEC_STRIDE = VEC_STRIDE_DEFAULT
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NIRQ-1:0]               irq,
   input  logic                          ien_we,
   input  logic [NIRQ-1:0]               ien_wd,
   input  logic                          gie_we,
   input  logic                          gie_wd,
   input  logic [NIRQ-1:0]               pend_clr,
   input  logic                          reti,
   output logic                          int_take,
   output logic                          kill,
   output logic [9:0]                    int_vector,
   output logic [irq_id_width(NIRQ)-1:0] irq_id,
   output logic                          in_service,
   output logic [NIRQ-1:0]               pending
);

   localparam int IDW = irq_id_width(NIRQ);

   logic [1:0]      state_q,    state_d;
   logic [NIRQ-1:0] pending_q,  pending_d;
   logic [NIRQ-1:0] ien_q,      ien_d;
   logic [NIRQ-1:0] irq_prev_q, irq_prev_d;
   logic            gie_q,      gie_d;
   logic [IDW-1:0]  irq_id_q,   irq_id_d;

   logic [NIRQ-1:0] irq_rise;
   logic            sel_valid;
   logic [IDW-1:0]  sel_id;
   logic            req;

   // Pick the lowest-numbered line that is both pending and enabled.
   prio_enc #(
      .NIRQ (NIRQ)
   ) u_prio_enc (
      .req   (pending_q & ien_q),
      .valid (sel_valid),
      .idx   (sel_id)
   );

   assign req = gie_q & sel_valid;

   // Pending bits: clears are applied first and new edges OR in afterwards,
   // so an edge in the same cycle as a clear leaves the bit set. Software
   // clears in the TAKE cycle come from the killed instruction and are
   // dropped; the TAKE cycle instead retires the bit being taken.
   always_comb begin
      irq_rise   = irq & ~irq_prev_q;
      irq_prev_d = irq;
      pending_d  = pending_q;
      if (state_q == TAKE) begin
         pending_d[irq_id_q] = 1'b0;
      end else begin
         pending_d = pending_d & ~pend_clr;
      end
      pending_d = pending_d | irq_rise;
   end

   // Sequencing and enable registers. The take decision looks only at
   // registered state, so after reti the controller spends at least one
   // cycle in IDLE and one main-program instruction runs between
   // interrupts. Enable writes issued by the killed instruction are ignored;
   // in SERVICE the reti restore of gie overrides a same-cycle gie write.
   always_comb begin
      state_d  = state_q;
      ien_d    = ien_q;
      gie_d    = gie_q;
      irq_id_d = irq_id_q;
      case (state_q)
         IDLE: begin
            if (ien_we) ien_d = ien_wd;
            if (gie_we) gie_d = gie_wd;
            if (req) begin
               state_d  = TAKE;
               irq_id_d = sel_id;
            end
         end
         TAKE: begin
            gie_d   = 1'b0;
            state_d = SERVICE;
         end
         SERVICE: begin
            if (ien_we) ien_d = ien_wd;
            if (gie_we) gie_d = gie_wd;
            if (reti) begin
               gie_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         ien_q      <= '0;
         irq_prev_q <= '0;
         gie_q      <= 1'b0;
         irq_id_q   <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         ien_q      <= ien_d;
         irq_prev_q <= irq_prev_d;
         gie_q      <= gie_d;
         irq_id_q   <= irq_id_d;
      end
   end

   // Outputs decode directly from registered state so reset drops them at
   // once. The vector wraps within the 10-bit program address space.
   assign int_take   = (state_q == TAKE);
   assign kill       = (state_q == TAKE);
   assign in_service = (state_q == TAKE) || (state_q == SERVICE);
   assign irq_id     = irq_id_q;
   assign pending    = pending_q;
   assign int_vector = VEC_BASE + 10'(32'(irq_id_q) * VEC_STRIDE);

endmodule
